modesel_luma16x16: RTL and testbench
====================================

// Module: modesel_luma16x16
// PURPOSE
// - Intra 16x16 luma mode-decision engine; the consumer of the luma 16x16 predictor's outputs.
// - Streams one 16-pixel row per accepted beat of the original block together with the V, H and DC prediction rows.
// - Accumulates a per-mode SAD over the block and reports the best mode and its SAD.
// - Sits between the intra predictor and the residual/transform stage.
// PARAMETERS
// - PIX_W  8   pixel width, bits.
// - N      16  block dimension: pixels per row and rows per block.
// - SAD_W  16  SAD accumulator width. Must be >= PIX_W + 2*$clog2(N); no saturation needed.
// PORTS
// - clk        in   1        rising-edge clock.
// - reset      in   1        asynchronous, active-low reset.
// - start      in   1        begin a new block. Sampled only in IDLE.
// - row_valid  in   1        row beat valid.
// - row_ready  out  1        row beat accepted when row_valid & row_ready.
// - orig_row   in   N*PIX_W  original pixels. Pixel k (column k) is at [k*PIX_W +: PIX_W].
// - vpred_row  in   N*PIX_W  vertical prediction row, same packing.
// - hpred_row  in   N*PIX_W  horizontal prediction row, same packing.
// - dcpred_row in   N*PIX_W  DC prediction row, same packing.
// - pplane_row in   N*PIX_W  plane prediction row. Present only with PLANE_MODE_EN.
// - out_valid  out  1        result valid; held until taken.
// - out_ready  in   1        result consumed when out_valid & out_ready.
// - best_mode  out  2        0=V, 1=H, 2=DC, 3=Plane (H.264 numbering).
// - best_sad   out  SAD_W    SAD of best_mode.
// BEHAVIOUR
// - Reset (reset=0, asynchronous): state=IDLE, row_ready=0, out_valid=0, best_mode=0, best_sad=0. Accumulators and row counter are cleared.
// - FSM IDLE -> ACCUM -> COMPARE -> DONE -> IDLE:
//   - IDLE: start=1 clears all SAD accumulators and row_cnt, then goes to ACCUM. start is ignored in every other state.
//   - ACCUM: row_ready=1. Each accepted beat adds, for every mode m, sum over k of |orig[k]-pred_m[k]| to sad_m and increments row_cnt.
//     The accept with row_cnt==N-1 moves to COMPARE. Gaps in row_valid stall without state change.
//   - COMPARE: one cycle, row_ready=0. Selects the minimum SAD and registers best_mode/best_sad. Goes to DONE.
//   - DONE: out_valid=1; best_mode and best_sad stay stable until out_ready=1. That cycle returns to IDLE with out_valid deasserted next edge.
// - Latency: out_valid rises on the 2nd rising edge after the last row is accepted.
// - Throughput: one row per clock. With immediate out_ready, a start in the cycle after out_valid drops gives back-to-back blocks.
// - Arithmetic:
//   - |a-b| is computed at PIX_W+1 signed width.
//   - The per-row sum is PIX_W+$clog2(N) bits; accumulation is unsigned SAD_W.
//   - Max SAD is N*N*(2^PIX_W-1) = 65280 at defaults, so no overflow.
// - Tie-break: strict less-than, scanned in mode order 0,1,2(,3). The lowest mode number wins on equal SAD.
// - row_valid outside ACCUM is ignored: no accept, no accumulation.
// - Asserting reset mid-block aborts it. No partial result is ever emitted, and the next block starts clean.
// CONFIGURATION
// - PLANE_MODE_EN defined:
//   - pplane_row port exists and a 4th accumulator sad_p is added.
//   - Mode 3 takes part in the compare and loses ties to modes 0-2.
// - PLANE_MODE_EN undefined:
//   - No pplane_row port and no 4th accumulator.
//   - best_mode is never 3.
// TESTING
// - Reset, then 16 rows with orig=100, V=100, H=90, DC=50 -> out_valid 2 cycles after row 16; best_mode=0, best_sad=0.
// - orig=200, V=0, H=199, DC=199 -> H/DC tie at SAD 256 -> best_mode=1, best_sad=256.
// - orig=255, all preds=0 -> every SAD=65280, no wrap; best_mode=0, best_sad=65280.
// - Random row_valid gaps plus out_ready held low 5 cycles in DONE:
//   - result matches the reference-model SAD and stays stable.
//   - row_ready=0 throughout DONE; start is ignored until return to IDLE.
// - reset pulled low after 7 rows -> all outputs 0 immediately; the next full block (orig=10, DC=10) gives best_mode=2, best_sad=0.
// - With PLANE_MODE_EN: plane row == orig, others offset by 1 -> best_mode=3, best_sad=0. Without it, the same stimulus gives best_mode=0, best_sad=256.

Source files
------------

// File: rtl/modesel_luma16x16.sv
// Intra 16x16 luma mode decision: per-mode SAD over 16 row beats, reports best mode/SAD (plane mode under PLANE_MODE_EN).
// Latency: out_valid rises 2 edges after the last accepted row; one row accepted per clock while accumulating.
// Backpressure: row_ready only in ACCUM; result held stable in DONE until out_ready.
module modesel_luma16x16 #(
    parameter int PIX_W = 8,
    parameter int N     = 16,
    parameter int SAD_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [N*PIX_W-1:0] orig_row,
    input  logic [N*PIX_W-1:0] vpred_row,
    input  logic [N*PIX_W-1:0] hpred_row,
    input  logic [N*PIX_W-1:0] dcpred_row,
`ifdef PLANE_MODE_EN
    input  logic [N*PIX_W-1:0] pplane_row,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         best_mode,
    output logic [SAD_W-1:0]   best_sad
);

    localparam int CW = $clog2(N);
    localparam int RW = PIX_W + CW;
`ifdef PLANE_MODE_EN
    localparam int NM = 4;
`else
    localparam int NM = 3;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      row_cnt;
    logic [SAD_W-1:0]   sad  [NM];
    logic [N*PIX_W-1:0] pred [NM];
    logic               accept;
    logic [1:0]         min_mode;
    logic [SAD_W-1:0]   min_sad;

    assign pred[0] = vpred_row;
    assign pred[1] = hpred_row;
    assign pred[2] = dcpred_row;
`ifdef PLANE_MODE_EN
    assign pred[3] = pplane_row;
`endif

    assign accept = row_valid && (state == ACCUM);

    // |a-b| at PIX_W+1 signed; the magnitude always fits back in PIX_W bits.
    function automatic logic [RW-1:0] row_sad(input logic [N*PIX_W-1:0] o, input logic [N*PIX_W-1:0] p);
        logic [RW-1:0]         acc;
        logic signed [PIX_W:0] d;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            d = $signed({1'b0, o[k*PIX_W +: PIX_W]}) - $signed({1'b0, p[k*PIX_W +: PIX_W]});
            if (d < 0) d = -d;
            acc = acc + RW'(d[PIX_W-1:0]);
        end
        return acc;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        row_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM: begin
                row_ready = 1'b1;
                if (row_valid && row_cnt == CW'(N-1)) state_nxt = COMPARE;
            end
            COMPARE: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict less-than in mode order: lower mode number wins ties.
    always_comb begin
        min_mode = 2'd0;
        min_sad  = sad[0];
        for (int m = 1; m < NM; m++) begin
            if (sad[m] < min_sad) begin
                min_sad  = sad[m];
                min_mode = 2'(m);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt   <= '0;
            best_mode <= 2'd0;
            best_sad  <= '0;
            for (int m = 0; m < NM; m++) sad[m] <= '0;
        end else begin
            if (state == IDLE && start) begin
                row_cnt <= '0;
                for (int m = 0; m < NM; m++) sad[m] <= '0;
            end else if (accept) begin
                row_cnt <= row_cnt + 1'b1;
                for (int m = 0; m < NM; m++) sad[m] <= sad[m] + SAD_W'(row_sad(orig_row, pred[m]));
            end
            if (state == COMPARE) begin
                best_mode <= min_mode;
                best_sad  <= min_sad;
            end
        end
    end

endmodule

// File: tb/tb_modesel_luma16x16.sv
// Scenario bench for modesel_luma16x16: expected results queued per block, popped when out_valid appears.
module tb_modesel_luma16x16;
    localparam int PIX_W = 8;
    localparam int N     = 16;
    localparam int SAD_W = 16;
`ifdef PLANE_MODE_EN
    localparam int NM = 4;
`else
    localparam int NM = 3;
`endif

    typedef struct packed {
        logic [1:0]       mode;
        logic [SAD_W-1:0] sad;
    } res_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               row_valid;
    logic               row_ready;
    logic [N*PIX_W-1:0] orig_row, vpred_row, hpred_row, dcpred_row;
`ifdef PLANE_MODE_EN
    logic [N*PIX_W-1:0] pplane_row;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         best_mode;
    logic [SAD_W-1:0]   best_sad;

    int n_cmp = 0;
    int n_bad = 0;

    int bo [N][N];
    int bv [N][N];
    int bh [N][N];
    int bd [N][N];
    int bp [N][N];

    res_t exp_q[$];

    always #5 clk = ~clk;

    modesel_luma16x16 #(.PIX_W(PIX_W), .N(N), .SAD_W(SAD_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .row_valid(row_valid), .row_ready(row_ready),
        .orig_row(orig_row), .vpred_row(vpred_row), .hpred_row(hpred_row), .dcpred_row(dcpred_row),
`ifdef PLANE_MODE_EN
        .pplane_row(pplane_row),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .best_mode(best_mode), .best_sad(best_sad)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic res_t model();
        int   s [4];
        int   bm, bs;
        res_t r;
        for (int m = 0; m < 4; m++) s[m] = 0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                s[0] += absd(bo[i][k], bv[i][k]);
                s[1] += absd(bo[i][k], bh[i][k]);
                s[2] += absd(bo[i][k], bd[i][k]);
                s[3] += absd(bo[i][k], bp[i][k]);
            end
        bm = 0;
        bs = s[0];
        for (int m = 1; m < NM; m++)
            if (s[m] < bs) begin bs = s[m]; bm = m; end
        r.mode = 2'(bm);
        r.sad  = SAD_W'(bs);
        return r;
    endfunction

    task automatic fill_uniform(input int o, input int v, input int h, input int d, input int p);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                bo[i][k] = o; bv[i][k] = v; bh[i][k] = h; bd[i][k] = d; bp[i][k] = p;
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                bo[i][k] = $urandom_range(255);
                bv[i][k] = $urandom_range(255);
                bh[i][k] = $urandom_range(255);
                bd[i][k] = $urandom_range(255);
                bp[i][k] = $urandom_range(255);
            end
    endtask

    task automatic drive_row(input int r);
        for (int k = 0; k < N; k++) begin
            orig_row[k*PIX_W +: PIX_W]   = PIX_W'(bo[r][k]);
            vpred_row[k*PIX_W +: PIX_W]  = PIX_W'(bv[r][k]);
            hpred_row[k*PIX_W +: PIX_W]  = PIX_W'(bh[r][k]);
            dcpred_row[k*PIX_W +: PIX_W] = PIX_W'(bd[r][k]);
`ifdef PLANE_MODE_EN
            pplane_row[k*PIX_W +: PIX_W] = PIX_W'(bp[r][k]);
`endif
        end
    endtask

    // Starts a block, streams all rows (optionally with gaps) and checks the 2-edge result latency.
    task automatic run_block(input bit gaps);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (row_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accum_ready: row_ready=%b want 1", row_ready);
        end
        exp_q.push_back(model());
        for (int r = 0; r < N; r++) begin
            if (gaps) begin
                repeat ($urandom_range(2)) begin
                    row_valid = 1'b0;
                    drive_row(N - 1 - r);
                    tick();
                end
            end
            drive_row(r);
            row_valid = 1'b1;
            tick();
        end
        row_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || row_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL compare_cycle: out_valid=%b row_ready=%b want 0 0", out_valid, row_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency: out_valid=%b want 1 two edges after last row", out_valid);
        end
    endtask

    // Waits for the result, holds out_ready low for 'hold' cycles (poking start/row_valid), then takes it.
    task automatic collect(input int hold, input string name);
        int   waited;
        res_t e;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s timeout: out_valid=%b queued=%0d want result", name, out_valid, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        for (int c = 0; c < hold; c++) begin
            start     = 1'b1;
            row_valid = 1'b1;
            n_cmp++;
            if (best_mode !== e.mode || best_sad !== e.sad || out_valid !== 1'b1 || row_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold%0d: mode=%0d sad=%0d vld=%b rdy=%b want mode=%0d sad=%0d vld=1 rdy=0",
                         name, c, best_mode, best_sad, out_valid, row_ready, e.mode, e.sad);
            end
            tick();
        end
        start     = 1'b0;
        row_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (best_mode !== e.mode || best_sad !== e.sad) begin
            n_bad++;
            $display("FAIL %s result: mode=%0d sad=%0d want mode=%0d sad=%0d", name, best_mode, best_sad, e.mode, e.sad);
        end
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || row_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release: out_valid=%b row_ready=%b want 0 0", name, out_valid, row_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; row_valid = 1'b0; out_ready = 1'b0;
        fill_uniform(0, 0, 0, 0, 0);
        drive_row(0);
        tick();
        tick();
        n_cmp++;
        if (row_ready !== 1'b0 || out_valid !== 1'b0 || best_mode !== 2'd0 || best_sad !== '0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b vld=%b mode=%0d sad=%0d want 0 0 0 0", row_ready, out_valid, best_mode, best_sad);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_exact_v();
        fill_uniform(100, 100, 90, 50, 60);
        run_block(1'b0);
        collect(0, "exact_v");
    endtask

    task automatic test_tie_h_dc();
        fill_uniform(200, 0, 199, 199, 0);
        run_block(1'b0);
        collect(0, "tie_h_dc");
    endtask

    task automatic test_max_sad();
        fill_uniform(255, 0, 0, 0, 0);
        run_block(1'b0);
        collect(0, "max_sad");
    endtask

    task automatic test_random_gaps();
        fill_random();
        row_valid = 1'b1;
        drive_row(3);
        repeat (3) tick();
        row_valid = 1'b0;
        run_block(1'b1);
        collect(5, "random_gaps");
        fill_random();
        run_block(1'b1);
        collect(2, "random_gaps2");
    endtask

    task automatic test_abort();
        fill_uniform(30, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            drive_row(r);
            row_valid = 1'b1;
            tick();
        end
        row_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (row_ready !== 1'b0 || out_valid !== 1'b0 || best_mode !== 2'd0 || best_sad !== '0) begin
            n_bad++;
            $display("FAIL abort: rdy=%b vld=%b mode=%0d sad=%0d want 0 0 0 0", row_ready, out_valid, best_mode, best_sad);
        end
        tick();
        reset = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_result: out_valid=%b want 0", out_valid);
        end
        fill_uniform(10, 40, 70, 10, 90);
        run_block(1'b0);
        collect(0, "after_abort");
    endtask

    task automatic test_plane();
        fill_uniform(50, 51, 49, 51, 50);
        run_block(1'b0);
        collect(0, "plane");
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_block(1'b0);
        collect(0, "b2b_a");
        fill_uniform(0, 255, 1, 2, 3);
        run_block(1'b0);
        collect(0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_exact_v();
        test_tie_h_dc();
        test_max_sad();
        test_random_gaps();
        test_abort();
        test_plane();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: queued=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
